mult_cell_pipe: RTL and testbench

Parametrised, pipelined integer multiplier for the Nios II-class CPU execute/memory path. It is the next generation of the three-partial-product multiply cell. It takes two DATA_W-bit operands and per-operand signedness, and returns the full 2·DATA_W-bit product after a fixed three-stage pipeline. It has a global stall enable, a synchronous flush and a tag carried alongside each operation, so mul, mulxss, mulxsu and mulxuu all share one unit.

---
 rtl/mult_cell_pkg.sv | 28 ++
 rtl/mult_cell_pp.sv | 33 +++
 rtl/mult_cell_pipe.sv | 148 ++++++++++++++
 tb/tb_mult_cell_pipe.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_cell_pkg.sv
// rtl/mult_cell_pkg.sv - sizing helpers and stage record shared by the mult_cell_pipe slice
package mult_cell_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 5;
    // Widest tag the shadow pipeline can carry; narrower tags are zero-extended.
    localparam int MAX_TAG_W  = 16;

    function automatic int half_of(input int data_w);
        return data_w / 2;
    endfunction

    // Width of a signed (HALF+1)x(HALF+1) partial product.
    function automatic int pp_w_of(input int data_w);
        return 2 * half_of(data_w) + 2;
    endfunction

    localparam int DEF_PP_W = pp_w_of(DEF_DATA_W);

    // Control sideband that travels alongside each stage of data.
    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic                 sign_a;
        logic                 sign_b;
    } stage_t;

endpackage

// File: rtl/mult_cell_pp.sv
// rtl/mult_cell_pp.sv - one registered signed (HALF+1)x(HALF+1) partial-product multiplier
module mult_cell_pp
    import mult_cell_pkg::*;
#(
    parameter int PP_W = DEF_PP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [PP_W/2-1:0] a,
    input  logic [PP_W/2-1:0] b,
    output logic [PP_W-1:0]   p
);

    localparam int OP_W = PP_W / 2;

    logic [PP_W-1:0] a_ext;
    logic [PP_W-1:0] b_ext;

    // Sign-extend to the product width so the truncated product is the exact signed result.
    assign a_ext = {{OP_W{a[OP_W-1]}}, a};
    assign b_ext = {{OP_W{b[OP_W-1]}}, b};

    // Product register advances only with the pipeline enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p <= '0;
        end else if (en) begin
            p <= a_ext * b_ext;
        end
    end

endmodule

// File: rtl/mult_cell_pipe.sv
// rtl/mult_cell_pipe.sv - 3-stage pipelined multiplier; MULT_CELL_FULL_PRODUCT_EN enables the upper product half
module mult_cell_pipe
    import mult_cell_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_sign_a,
    input  logic              in_sign_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_lo,
    output logic [DATA_W-1:0] out_hi,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int HALF = half_of(DATA_W);
    localparam int PP_W = pp_w_of(DATA_W);
`ifdef MULT_CELL_FULL_PRODUCT_EN
    localparam int RES_W = 2 * DATA_W;
`else
    localparam int RES_W = DATA_W;
`endif

    logic            ext_a;
    logic            ext_b;
    logic [HALF:0]   a_lo;
    logic [HALF:0]   a_hi;
    logic [HALF:0]   b_lo;
    logic [HALF:0]   b_hi;
    logic [PP_W-1:0] ll_p;
    logic [PP_W-1:0] lh_p;
    logic [PP_W-1:0] hl_p;
    logic [PP_W:0]   mid_sum;
    logic [RES_W-1:0] mid_ext;
    logic [RES_W-1:0] mid_q;
    logic [PP_W-1:0] ll_q;
    logic [RES_W-1:0] prod_next;
    logic [RES_W-1:0] prod_q;
    stage_t          ctl1;
    stage_t          ctl2;
    stage_t          ctl3;

`ifdef MULT_CELL_FULL_PRODUCT_EN
    logic [PP_W-1:0] hh_p;
    logic [PP_W-1:0] hh_q;

    assign ext_a = in_sign_a & in_a[DATA_W-1];
    assign ext_b = in_sign_b & in_b[DATA_W-1];
`else
    // The low half of a product does not depend on operand signedness.
    assign ext_a = 1'b0;
    assign ext_b = 1'b0;
`endif

    assign a_lo = {1'b0, in_a[HALF-1:0]};
    assign b_lo = {1'b0, in_b[HALF-1:0]};
    assign a_hi = {ext_a, in_a[DATA_W-1:HALF]};
    assign b_hi = {ext_b, in_b[DATA_W-1:HALF]};

    mult_cell_pp #(.PP_W(PP_W)) u_ll (.clk(clk), .reset(reset), .en(en), .a(a_lo), .b(b_lo), .p(ll_p));
    mult_cell_pp #(.PP_W(PP_W)) u_lh (.clk(clk), .reset(reset), .en(en), .a(a_lo), .b(b_hi), .p(lh_p));
    mult_cell_pp #(.PP_W(PP_W)) u_hl (.clk(clk), .reset(reset), .en(en), .a(a_hi), .b(b_lo), .p(hl_p));
`ifdef MULT_CELL_FULL_PRODUCT_EN
    mult_cell_pp #(.PP_W(PP_W)) u_hh (.clk(clk), .reset(reset), .en(en), .a(a_hi), .b(b_hi), .p(hh_p));
`endif

    // Exact signed sum of the two cross terms, one bit wider than either.
    assign mid_sum = {lh_p[PP_W-1], lh_p} + {hl_p[PP_W-1], hl_p};

`ifdef MULT_CELL_FULL_PRODUCT_EN
    assign mid_ext = {{(RES_W-PP_W-1){mid_sum[PP_W]}}, mid_sum};
`else
    assign mid_ext = RES_W'(mid_sum);
`endif

    // Stage 2: combine cross terms, carry ll (and hh) forward.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mid_q <= '0;
            ll_q  <= '0;
`ifdef MULT_CELL_FULL_PRODUCT_EN
            hh_q  <= '0;
`endif
        end else if (en) begin
            mid_q <= mid_ext;
            ll_q  <= ll_p;
`ifdef MULT_CELL_FULL_PRODUCT_EN
            hh_q  <= hh_p;
`endif
        end
    end

    // Final weighted sum, wrapping at the result width.
    always_comb begin
        prod_next = (mid_q << HALF) + RES_W'(ll_q);
`ifdef MULT_CELL_FULL_PRODUCT_EN
        prod_next = prod_next + ({{(RES_W-PP_W){hh_q[PP_W-1]}}, hh_q} << DATA_W);
`endif
    end

    // Stage 3: product register feeding the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
        end else if (en) begin
            prod_q <= prod_next;
        end
    end

    // Control shadow pipeline; flush kills every valid bit even while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl1 <= '0;
            ctl2 <= '0;
            ctl3 <= '0;
        end else if (flush) begin
            ctl1.valid <= 1'b0;
            ctl2.valid <= 1'b0;
            ctl3.valid <= 1'b0;
        end else if (en) begin
            ctl1.valid  <= in_valid;
            ctl1.tag    <= MAX_TAG_W'(in_tag);
            ctl1.sign_a <= in_sign_a;
            ctl1.sign_b <= in_sign_b;
            ctl2        <= ctl1;
            ctl3        <= ctl2;
        end
    end

    assign out_valid = ctl3.valid;
    // The tag sits directly above the two sign bits in the record.
    assign out_tag   = TAG_W'(ctl3 >> 2);
    assign out_lo    = prod_q[DATA_W-1:0];
`ifdef MULT_CELL_FULL_PRODUCT_EN
    assign out_hi    = prod_q[RES_W-1:DATA_W];
`else
    assign out_hi    = '0;
`endif

endmodule

// File: tb/tb_mult_cell_pipe.sv
// tb/tb_mult_cell_pipe.sv - self-checking bench for mult_cell_pipe
module tb_mult_cell_pipe;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;
`ifdef MULT_CELL_FULL_PRODUCT_EN
    localparam bit FULL = 1'b1;
`else
    localparam bit FULL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_sign_a;
    logic              in_sign_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic [DATA_W-1:0] out_lo;
    logic [DATA_W-1:0] out_hi;
    logic [TAG_W-1:0]  out_tag;

    mult_cell_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
        .in_tag(in_tag), .out_valid(out_valid), .out_lo(out_lo), .out_hi(out_hi),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb;
        logic [4:0]  tag;
        int          stamp;
    } op_t;

    op_t q[$];
    int  en_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic sa, input logic sb);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {(sa ? {32{a[31]}} : 32'h0), a};
        bx = {(sb ? {32{b[31]}} : 32'h0), b};
        return ax * bx;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Result of the oldest op appears once it has seen three enabled edges.
    task automatic check_out();
        logic        exp_v;
        logic [63:0] p;
        exp_v = (q.size() > 0) && ((en_cnt - q[0].stamp) == 2);
        check("out_valid", 64'(out_valid), 64'(exp_v));
        if (exp_v) begin
            p = ref_prod(q[0].a, q[0].b, q[0].sa, q[0].sb);
            check("out_lo", 64'(out_lo), 64'(p[31:0]));
            check("out_hi", 64'(out_hi), FULL ? 64'(p[63:32]) : 64'h0);
            check("out_tag", 64'(out_tag), 64'(q[0].tag));
        end
    endtask

    task automatic cycle(input logic e, input logic fl, input logic v,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb, input logic [4:0] tag);
        en = e; flush = fl; in_valid = v;
        in_a = a; in_b = b; in_sign_a = sa; in_sign_b = sb; in_tag = tag;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else if (e) begin
            en_cnt++;
            while (q.size() > 0 && (en_cnt - q[0].stamp) > 2) void'(q.pop_front());
            if (v) q.push_back('{a, b, sa, sb, tag, en_cnt});
        end
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    endtask

    vec_t        tbl[12];
    logic [7:0]  stall_v;
    logic [4:0]  stall_tag[8];

    initial begin
        tbl[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE};
        tbl[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0000};
        tbl[2]  = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFF};
        tbl[3]  = '{32'hFFFF_FFFE, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[4]  = '{32'h0000_0007, 32'h0000_0006, 1'b0, 1'b0, 32'h0000_002A, 32'h0000_0000};
        tbl[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0000, 32'h4000_0000};
        tbl[6]  = '{32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0001};
        tbl[7]  = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0000, 32'hC000_0000};
        tbl[8]  = '{32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        tbl[9]  = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000};
        tbl[10] = '{32'h8000_0000, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0001};
        tbl[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF};

        stall_v = 8'b0111_0000;
        stall_tag = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0};

        reset = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_sign_a = 1'b0; in_sign_b = 1'b0; in_tag = '0;
        #12;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_lo", 64'(out_lo), 64'h0);
        check("rst_hi", 64'(out_hi), 64'h0);
        check("rst_tag", 64'(out_tag), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors, each issued alone and read after the third edge.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, 1'b1, tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb, 5'(i));
            idle(1);
            check("tbl_early", 64'(out_valid), 64'h0);
            idle(1);
            check("tbl_valid", 64'(out_valid), 64'h1);
            check("tbl_lo", 64'(out_lo), 64'(tbl[i].lo));
            check("tbl_hi", 64'(out_hi), FULL ? 64'(tbl[i].hi) : 64'h0);
        end
        idle(2);

        // Stream 1,2,3 with a two-cycle stall after tag 2 enters.
        for (int s = 0; s < 8; s++) begin
            case (s)
                0:       cycle(1'b1, 1'b0, 1'b1, 32'd3, 32'd5, 1'b0, 1'b0, 5'd1);
                1:       cycle(1'b1, 1'b0, 1'b1, 32'd7, 32'd9, 1'b0, 1'b0, 5'd2);
                2, 3:    cycle(1'b0, 1'b0, 1'b1, 32'd11, 32'd13, 1'b0, 1'b0, 5'd3);
                4:       cycle(1'b1, 1'b0, 1'b1, 32'd11, 32'd13, 1'b0, 1'b0, 5'd3);
                default: cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
            endcase
            check("stall_valid", 64'(out_valid), 64'(stall_v[s]));
            if (stall_v[s]) check("stall_tag", 64'(out_tag), 64'(stall_tag[s]));
        end

        // Flush with three ops in flight and a fourth offered in the same cycle.
        cycle(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 5'd4);
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b1, 5'd5);
        cycle(1'b1, 1'b0, 1'b1, 32'h8000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 5'd6);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 5'd7);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("flush_quiet", 64'(out_valid), 64'h0);
        end
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0, 5'd8);
        idle(2);
        check("post_flush_valid", 64'(out_valid), 64'h1);
        check("post_flush_lo", 64'(out_lo), 64'hFFFF_FFFA);

        // Asynchronous reset in the middle of a stream.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 5'd9);
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'h0000_0040, 1'b0, 1'b0, 5'd10);
        idle(1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_lo", 64'(out_lo), 64'h0);
        check("mid_rst_hi", 64'(out_hi), 64'h0);
        check("mid_rst_tag", 64'(out_tag), 64'h0);
        q.delete();
        @(posedge clk);
        #1;
        check("rst_hold_valid", 64'(out_valid), 64'h0);
        reset = 1'b0;
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b0, 1'b0, 5'd11);
        idle(4);

        // Random traffic with stalls and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            logic        e;
            logic        fl;
            logic        v;
            logic [31:0] a;
            logic [31:0] b;
            logic        sa;
            logic        sb;
            logic [4:0]  tg;
            e  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 24) == 0);
            v  = ($urandom_range(0, 9) < 7);
            a  = pick_operand();
            b  = pick_operand();
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            tg = 5'($urandom_range(0, 31));
            cycle(e, fl, v, a, b, sa, sb, tg);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
